// File: rtl/ghost_collision_scheduler.sv
// ghost_collision_scheduler: per-frame Pac-Man/ghost collision scan sharing one squarer across four ghosts,
// with crash debouncing through an invulnerability window counted in completed scans.
module ghost_collision_scheduler #(
  parameter logic [20:0] THRESH = 21'd2048,
  parameter logic [7:0] INVUL_SCANS = 8'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic [9:0] PacX,
  input  logic [8:0] PacY,
  input  logic [9:0] Ghost1X,
  input  logic [9:0] Ghost2X,
  input  logic [9:0] Ghost3X,
  input  logic [9:0] Ghost4X,
  input  logic [8:0] Ghost1Y,
  input  logic [8:0] Ghost2Y,
  input  logic [8:0] Ghost3Y,
  input  logic [8:0] Ghost4Y,
  input  logic [3:0] GhostEn,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] HitVec,
  output logic       Crash,
  output logic [1:0] CrashIdx,
  output logic       Invul
);
  typedef enum logic [1:0] {IDLE, SQX, SQY, CMP} state_t;
  state_t state_q, state_d;
  logic [1:0] g_q, g_d, idx_q, idx_d;
  logic [9:0] px_q, px_d;
  logic [8:0] py_q, py_d;
  logic [3:0][9:0] gx_q, gx_d;
  logic [3:0][8:0] gy_q, gy_d;
  logic [3:0] en_q, en_d, hit_q, hit_d, hv_q, hv_d, hit_all;
  logic [20:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic done_q, done_d, crash_q, crash_d, hit_g, last, accept;
  logic [9:0] gxs, dx, mul_a;
  logic [8:0] gys, dy;
  logic [19:0] prod;
  assign gxs = gx_q[g_q];
  assign gys = gy_q[g_q];
  assign dx = px_q >= gxs ? px_q - gxs : gxs - px_q;
  assign dy = py_q >= gys ? py_q - gys : gys - py_q;
  // Single squarer: fed dx in SQX and zero-extended dy in SQY
  assign mul_a = state_q == SQX ? dx : {1'b0, dy};
  assign prod = {10'd0, mul_a} * {10'd0, mul_a};
  assign hit_g = en_q[g_q] & (acc_q < THRESH);
  assign hit_all = hit_q | ({3'b0, hit_g} << g_q);
  assign last = state_q == CMP && g_q == 2'd3;
  assign accept = last && |hit_all && cnt_q == 8'd0;
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    px_d = px_q;
    py_d = py_q;
    gx_d = gx_q;
    gy_d = gy_q;
    en_d = en_q;
    hit_d = hit_q;
    acc_d = acc_q;
    hv_d = hv_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    crash_d = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        px_d = PacX;
        py_d = PacY;
        gx_d = {Ghost4X, Ghost3X, Ghost2X, Ghost1X};
        gy_d = {Ghost4Y, Ghost3Y, Ghost2Y, Ghost1Y};
        en_d = GhostEn;
        hit_d = 4'd0;
        g_d = 2'd0;
        state_d = SQX;
      end
      SQX: begin
        acc_d = {1'b0, prod};
        state_d = SQY;
      end
      SQY: begin
        acc_d = acc_q + {1'b0, prod};
        state_d = CMP;
      end
      CMP: begin
        hit_d = hit_all;
        g_d = g_q + 2'd1;
        state_d = last ? IDLE : SQX;
        hv_d = last ? hit_all : hv_q;
        done_d = last;
        crash_d = accept;
        idx_d = !accept ? idx_q : hit_all[0] ? 2'd0 : hit_all[1] ? 2'd1 : hit_all[2] ? 2'd2 : 2'd3;
        cnt_d = accept ? INVUL_SCANS : (last && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q <= '0;
      px_q <= '0;
      py_q <= '0;
      gx_q <= '0;
      gy_q <= '0;
      en_q <= '0;
      hit_q <= '0;
      acc_q <= '0;
      hv_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      crash_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      px_q <= px_d;
      py_q <= py_d;
      gx_q <= gx_d;
      gy_q <= gy_d;
      en_q <= en_d;
      hit_q <= hit_d;
      acc_q <= acc_d;
      hv_q <= hv_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      crash_q <= crash_d;
    end
  end
  assign Busy = state_q != IDLE;
  assign Done = done_q;
  assign HitVec = hv_q;
  assign Crash = crash_q;
  assign CrashIdx = idx_q;
  assign Invul = |cnt_q;
endmodule

// File: tb/tb_ghost_collision_scheduler.sv
// tb_ghost_collision_scheduler: scoreboard bench; a behavioural model queues expected scan results at Start.
module tb_ghost_collision_scheduler;
  localparam logic [7:0] INV = 8'd2;
  logic clk = 1'b0, rst = 1'b1, Start = 1'b0;
  logic [9:0] px;
  logic [8:0] py;
  logic [9:0] gx [4];
  logic [8:0] gy [4];
  logic [3:0] en;
  logic busy, done, crash, invul;
  logic [3:0] hitvec;
  logic [1:0] crash_idx;
  typedef struct {
    int at;
    logic [3:0] hv;
    logic crash;
    logic [1:0] idx;
    logic invul;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, cyc = 0, m_cnt = 0;
  logic [1:0] m_idx = 2'd0;
  ghost_collision_scheduler #(.THRESH(21'd2048), .INVUL_SCANS(INV)) dut (
    .clk(clk), .rst(rst), .Start(Start), .PacX(px), .PacY(py),
    .Ghost1X(gx[0]), .Ghost2X(gx[1]), .Ghost3X(gx[2]), .Ghost4X(gx[3]),
    .Ghost1Y(gy[0]), .Ghost2Y(gy[1]), .Ghost3Y(gy[2]), .Ghost4Y(gy[3]),
    .GhostEn(en), .Busy(busy), .Done(done), .HitVec(hitvec), .Crash(crash),
    .CrashIdx(crash_idx), .Invul(invul)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc, e.at);
        chk("hitvec", hitvec, e.hv);
        chk("crash", crash, e.crash);
        chk("crash_idx", crash_idx, e.idx);
        chk("invul", invul, e.invul);
        chk("busy_at_done", busy, 0);
      end
    end else if (crash) chk("crash_without_done", crash, 0);
  end
  task automatic push_exp();
    exp_t x;
    int dx, dy;
    logic [3:0] hv;
    for (int i = 0; i < 4; i++) begin
      dx = int'(px) - int'(gx[i]);
      dy = int'(py) - int'(gy[i]);
      hv[i] = en[i] && (dx * dx + dy * dy < 2048);
    end
    x.crash = hv != 0 && m_cnt == 0;
    if (x.crash) begin
      m_idx = hv[0] ? 2'd0 : hv[1] ? 2'd1 : hv[2] ? 2'd2 : 2'd3;
      m_cnt = int'(INV);
    end else if (m_cnt > 0) m_cnt--;
    x.at = cyc + 13;
    x.hv = hv;
    x.idx = m_idx;
    x.invul = m_cnt != 0;
    q.push_back(x);
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask
  task automatic run_scan();
    @(negedge clk);
    Start = 1'b1;
    push_exp();
    @(negedge clk);
    Start = 1'b0;
    chk("busy", busy, 1);
    drain();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hitvec", hitvec, 0);
    chk("rst_crash", crash, 0);
    chk("rst_idx", crash_idx, 0);
    chk("rst_invul", invul, 0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_cnt = 0;
    m_idx = 2'd0;
  endtask
  task automatic place(input int i, input int x, input int y);
    gx[i] = x[9:0];
    gy[i] = y[8:0];
  endtask
  task automatic all_far();
    for (int i = 0; i < 4; i++) place(i, 400, 300);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    px = 10'd100;
    py = 9'd100;
    en = 4'b0000;
    all_far();
    repeat (2) @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_hitvec", hitvec, 0);
    chk("init_invul", invul, 0);
    rst = 1'b0;
    en = 4'b1111;
    place(1, 130, 110);
    run_scan();
    do_reset();
    all_far();
    place(0, 132, 100);
    run_scan();
    place(0, 55, 91);
    run_scan();
    place(0, 132, 132);
    run_scan();
    do_reset();
    place(0, 100, 100);
    place(1, 400, 300);
    place(2, 101, 100);
    place(3, 100, 101);
    en = 4'b1011;
    run_scan();
    do_reset();
    en = 4'b1010;
    run_scan();
    do_reset();
    en = 4'b1111;
    repeat (4) run_scan();
    do_reset();
    all_far();
    place(0, 100, 100);
    @(negedge clk);
    Start = 1'b1;
    push_exp();
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    place(0, 400, 300);
    place(2, 100, 100);
    repeat (3) @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (6) @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    push_exp();
    @(negedge clk);
    Start = 1'b0;
    drain();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (4) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    run_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
